// File: rtl/boot_loader_ctrl_pkg.sv
// Shared bus defaults and idle levels for the boot loader and the CPU/RAM bus it sits on.
package boot_loader_ctrl_pkg;

  localparam int          BL_ADDR_W    = 16;
  localparam int          BL_DATA_W    = 8;
  localparam logic [15:0] BL_LOAD_BASE = 16'h0000;

  // Active-low strobes: the idle (deasserted) level is high.
  localparam logic OE_IDLE = 1'b1;
  localparam logic WE_IDLE = 1'b1;

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Image stream, CPU bus and RAM bus of the boot loader, grouped as one bundle.
interface boot_loader_ctrl_if
  import boot_loader_ctrl_pkg::*;
#(
  parameter int ADDR_W = BL_ADDR_W,
  parameter int DATA_W = BL_DATA_W
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic              reload;
  logic [ADDR_W-1:0] cpu_a;
  logic              cpu_oe;
  logic              cpu_we;
  logic              cpu_rst_n;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_oe;
  logic              mem_we;
  logic [DATA_W-1:0] ld_d;
  logic              ld_d_en;
  logic              done;
  logic              wrapped;
  logic [ADDR_W:0]   byte_count;

  modport master (
    output s_data, s_valid, s_last, reload, cpu_a, cpu_oe, cpu_we,
    input  s_ready, cpu_rst_n, mem_a, mem_oe, mem_we, ld_d, ld_d_en, done, wrapped, byte_count
  );

  modport slave (
    input  s_data, s_valid, s_last, reload, cpu_a, cpu_oe, cpu_we,
    output s_ready, cpu_rst_n, mem_a, mem_oe, mem_we, ld_d, ld_d_en, done, wrapped, byte_count
  );

endinterface

// File: rtl/boot_loader_ctrl_mem_write_seq.sv
// Write strobe timer: one setup cycle, STROBE_CYCLES of we_n low, one hold cycle per start pulse.
module boot_loader_ctrl_mem_write_seq
  import boot_loader_ctrl_pkg::*;
#(
  parameter int STROBE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_we_n,
  output logic o_strobe_end
);

  localparam logic [1:0] SQ_IDLE   = 2'd0;
  localparam logic [1:0] SQ_SETUP  = 2'd1;
  localparam logic [1:0] SQ_STROBE = 2'd2;
  localparam logic [1:0] SQ_HOLD   = 2'd3;

  localparam int               CNT_W    = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we_n;

  // we_n comes straight from a flop so it cannot glitch; async reset raises it immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SQ_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_we_n  <= WE_IDLE;
    end else begin
      case (r_state)
        SQ_IDLE: begin
          if (i_start) r_state <= SQ_SETUP;
        end
        SQ_SETUP: begin
          r_state <= SQ_STROBE;
          r_we_n  <= ~WE_IDLE;
          r_cnt   <= {CNT_W{1'b0}};
        end
        SQ_STROBE: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= SQ_HOLD;
            r_we_n  <= WE_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        SQ_HOLD: begin
          r_state <= SQ_IDLE;
        end
        default: begin
          r_state <= SQ_IDLE;
          r_we_n  <= WE_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = (r_state != SQ_IDLE);
  assign o_we_n       = r_we_n;
  assign o_strobe_end = (r_state == SQ_STROBE) && (r_cnt == CNT_LAST);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Loads a program image into RAM while holding the CPU in reset, then hands the RAM bus to the CPU.
module boot_loader_ctrl
  import boot_loader_ctrl_pkg::*;
#(
  parameter int                ADDR_W        = BL_ADDR_W,
  parameter int                DATA_W        = BL_DATA_W,
  parameter logic [ADDR_W-1:0] LOAD_BASE     = ADDR_W'(BL_LOAD_BASE),
  parameter int                STROBE_CYCLES = 1
) (
  input logic               clk,
  input logic               rst,
  boot_loader_ctrl_if.slave bus
);

  localparam logic [2:0] ST_WAIT   = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_STROBE = 3'd2;
  localparam logic [2:0] ST_HOLD   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_mem_a;
  logic [DATA_W-1:0] r_ld_d;
  logic              r_last;
  logic              r_s_ready;
  logic              r_ld_d_en;
  logic              r_cpu_rst_n;
  logic              r_done;
  logic              r_wrapped;
  logic [ADDR_W:0]   r_byte_count;

  logic w_start;
  logic w_seq_busy;
  logic w_seq_we_n;
  logic w_seq_strobe_end;

  assign w_start = (r_state == ST_WAIT) && r_s_ready && bus.s_valid && !w_seq_busy;

  boot_loader_ctrl_mem_write_seq #(
    .STROBE_CYCLES (STROBE_CYCLES)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_start),
    .o_busy       (w_seq_busy),
    .o_we_n       (w_seq_we_n),
    .o_strobe_end (w_seq_strobe_end)
  );

  // Loader FSM; the sequencer starts on the same edge, so both stay phase-aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_WAIT;
      r_addr       <= LOAD_BASE;
      r_mem_a      <= LOAD_BASE;
      r_ld_d       <= {DATA_W{1'b0}};
      r_last       <= 1'b0;
      r_s_ready    <= 1'b0;
      r_ld_d_en    <= 1'b0;
      r_cpu_rst_n  <= 1'b0;
      r_done       <= 1'b0;
      r_wrapped    <= 1'b0;
      r_byte_count <= {(ADDR_W+1){1'b0}};
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (w_start) begin
            r_s_ready <= 1'b0;
            r_ld_d    <= bus.s_data;
            r_last    <= bus.s_last;
            r_mem_a   <= r_addr;
            r_ld_d_en <= 1'b1;
            r_state   <= ST_SETUP;
          end else begin
            r_s_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          r_state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (w_seq_strobe_end) r_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_byte_count != COUNT_MAX) r_byte_count <= r_byte_count + COUNT_ONE;
          r_ld_d_en <= 1'b0;
          if (r_last) begin
            r_state     <= ST_DONE;
            r_cpu_rst_n <= 1'b1;
            r_done      <= 1'b1;
          end else begin
            // A final byte at the top address never increments, so wrapped is only set here
            r_addr    <= r_addr + ADDR_ONE;
            if (&r_addr) r_wrapped <= 1'b1;
            r_state   <= ST_WAIT;
            r_s_ready <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.reload) begin
            r_state      <= ST_WAIT;
            r_cpu_rst_n  <= 1'b0;
            r_done       <= 1'b0;
            r_addr       <= LOAD_BASE;
            r_mem_a      <= LOAD_BASE;
            r_wrapped    <= 1'b0;
            r_byte_count <= {(ADDR_W+1){1'b0}};
            r_s_ready    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_WAIT;
          r_s_ready <= 1'b0;
          r_ld_d_en <= 1'b0;
        end
      endcase
    end
  end

  // Bus ownership flips on the registered done flag, so the mux select itself is clean
  assign bus.mem_a      = r_done ? bus.cpu_a  : r_mem_a;
  assign bus.mem_oe     = r_done ? bus.cpu_oe : OE_IDLE;
  assign bus.mem_we     = r_done ? bus.cpu_we : w_seq_we_n;
  assign bus.s_ready    = r_s_ready;
  assign bus.cpu_rst_n  = r_cpu_rst_n;
  assign bus.ld_d       = r_ld_d;
  assign bus.ld_d_en    = r_ld_d_en;
  assign bus.done       = r_done;
  assign bus.wrapped    = r_wrapped;
  assign bus.byte_count = r_byte_count;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench: loader A (base 0000, 1-cycle strobe) and loader B (base FFFE, 3-cycle strobe).
module tb_boot_loader_ctrl;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   hs_cyc      = 0;
  int   hs_cyc_prev = 0;

  boot_loader_ctrl_if #(.ADDR_W(16), .DATA_W(8)) ifa ();
  boot_loader_ctrl_if #(.ADDR_W(16), .DATA_W(8)) ifb ();

  boot_loader_ctrl #(
    .ADDR_W(16), .DATA_W(8), .LOAD_BASE(16'h0000), .STROBE_CYCLES(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa));

  boot_loader_ctrl #(
    .ADDR_W(16), .DATA_W(8), .LOAD_BASE(16'hFFFE), .STROBE_CYCLES(3)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models and strobe/stability monitors, sampled on the falling edge
  logic [7:0]  ram_a [0:65535];
  logic [7:0]  ram_b [0:65535];
  int          run_a = 0, pulses_a = 0, plen_a = 0, stab_a = 0;
  int          run_b = 0, pulses_b = 0, plen_b = 0, stab_b = 0;
  logic        en_q_a = 1'b0, en_q_b = 1'b0;
  logic [15:0] cap_addr_a, cap_addr_b;
  logic [7:0]  cap_d_a, cap_d_b;

  always @(negedge clk) begin
    if (ifa.mem_we === 1'b0) run_a <= run_a + 1;
    else if (run_a != 0) begin
      pulses_a <= pulses_a + 1;
      plen_a   <= run_a;
      run_a    <= 0;
      if (ifa.ld_d_en) ram_a[ifa.mem_a] <= ifa.ld_d;
    end
    if (ifa.ld_d_en && !en_q_a) begin
      cap_addr_a <= ifa.mem_a;
      cap_d_a    <= ifa.ld_d;
    end else if (ifa.ld_d_en && (ifa.mem_a !== cap_addr_a || ifa.ld_d !== cap_d_a)) stab_a <= stab_a + 1;
    en_q_a <= ifa.ld_d_en;
  end

  always @(negedge clk) begin
    if (ifb.mem_we === 1'b0) run_b <= run_b + 1;
    else if (run_b != 0) begin
      pulses_b <= pulses_b + 1;
      plen_b   <= run_b;
      run_b    <= 0;
      if (ifb.ld_d_en) ram_b[ifb.mem_a] <= ifb.ld_d;
    end
    if (ifb.ld_d_en && !en_q_b) begin
      cap_addr_b <= ifb.mem_a;
      cap_d_b    <= ifb.ld_d;
    end else if (ifb.ld_d_en && (ifb.mem_a !== cap_addr_b || ifb.ld_d !== cap_d_b)) stab_b <= stab_b + 1;
    en_q_b <= ifb.ld_d_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ifa.s_ready : ifb.s_ready;
  endfunction

  function automatic logic dn(input int sel);
    return (sel == 0) ? ifa.done : ifb.done;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin
      ifa.s_valid = v; ifa.s_data = d; ifa.s_last = l;
    end else begin
      ifb.s_valid = v; ifb.s_data = d; ifb.s_last = l;
    end
  endtask

  // One byte: optional idle gap, handshake, then wait for WAIT or DONE
  task automatic send(input int sel, input logic [7:0] d, input logic l, input int pre_idle);
    logic got;
    for (int k = 0; k < pre_idle; k++) @(negedge clk);
    drive(sel, 1'b1, d, l);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rdy(sel)) begin got = 1'b1; break; end
      @(negedge clk);
    end
    chk("handshake", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    hs_cyc_prev = hs_cyc;
    hs_cyc      = cyc;
    drive(sel, 1'b0, d, l);
    chk("s_ready_drop", {31'd0, rdy(sel)}, 32'd0);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rdy(sel) || dn(sel)) begin got = 1'b1; break; end
    end
    chk("complete", {31'd0, got}, 32'd1);
  endtask

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic        last;
    logic [15:0] addr;
    logic [16:0] count;
    logic        wrapped;
    logic        done;
    int          plen;
    int          npulse;
    int          gap;
    int          pre_idle;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{0, 8'h3E, 1'b0, 16'h0000, 17'd1, 1'b0, 1'b0, 1, 1, 0, 0};
    vecs[1] = '{0, 8'h01, 1'b0, 16'h0001, 17'd2, 1'b0, 1'b0, 1, 2, 4, 0};
    vecs[2] = '{0, 8'hC9, 1'b1, 16'h0002, 17'd3, 1'b0, 1'b1, 1, 3, 4, 0};
    vecs[3] = '{1, 8'hAA, 1'b0, 16'hFFFE, 17'd1, 1'b0, 1'b0, 3, 1, 0, 5};
    vecs[4] = '{1, 8'hBB, 1'b0, 16'hFFFF, 17'd2, 1'b1, 1'b0, 3, 2, 0, 5};
    vecs[5] = '{1, 8'hCC, 1'b1, 16'h0000, 17'd3, 1'b1, 1'b1, 3, 3, 0, 5};

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    ifa.reload = 1'b0; ifa.cpu_a = 16'h0000; ifa.cpu_oe = 1'b1; ifa.cpu_we = 1'b1;
    ifb.reload = 1'b0; ifb.cpu_a = 16'h0000; ifb.cpu_oe = 1'b1; ifb.cpu_we = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready",   {31'd0, ifa.s_ready},   32'd0);
    chk("rst_mem_we",    {31'd0, ifa.mem_we},    32'd1);
    chk("rst_mem_oe",    {31'd0, ifa.mem_oe},    32'd1);
    chk("rst_cpu_rst_n", {31'd0, ifa.cpu_rst_n}, 32'd0);
    chk("rst_done",      {31'd0, ifa.done},      32'd0);
    chk("rst_ld_d_en",   {31'd0, ifa.ld_d_en},   32'd0);
    chk("rst_ld_d",      {24'd0, ifa.ld_d},      32'd0);
    chk("rst_count",     {15'd0, ifa.byte_count}, 32'd0);
    chk("rst_wrapped",   {31'd0, ifa.wrapped},   32'd0);
    chk("rst_mem_a_b",   {16'd0, ifb.mem_a},     32'h0000FFFE);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("s_ready_before_clk", {31'd0, ifa.s_ready}, 32'd0);
    @(posedge clk); #1;
    chk("s_ready_first_clk", {31'd0, ifa.s_ready}, 32'd1);

    // Image loads: A back-to-back, B with valid 1 cycle on / 5 off and a wrapping address
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].pre_idle);
      chk($sformatf("ram_%0d", i),
          {24'd0, (vecs[i].sel == 0) ? ram_a[vecs[i].addr] : ram_b[vecs[i].addr]}, {24'd0, vecs[i].data});
      chk($sformatf("count_%0d", i),
          {15'd0, (vecs[i].sel == 0) ? ifa.byte_count : ifb.byte_count}, {15'd0, vecs[i].count});
      chk($sformatf("wrapped_%0d", i),
          {31'd0, (vecs[i].sel == 0) ? ifa.wrapped : ifb.wrapped}, {31'd0, vecs[i].wrapped});
      chk($sformatf("done_%0d", i), {31'd0, dn(vecs[i].sel)}, {31'd0, vecs[i].done});
      chk($sformatf("cpu_rst_n_%0d", i),
          {31'd0, (vecs[i].sel == 0) ? ifa.cpu_rst_n : ifb.cpu_rst_n}, {31'd0, vecs[i].done});
      chk($sformatf("pulse_len_%0d", i), (vecs[i].sel == 0) ? plen_a : plen_b, vecs[i].plen);
      chk($sformatf("pulse_cnt_%0d", i), (vecs[i].sel == 0) ? pulses_a : pulses_b, vecs[i].npulse);
      if (vecs[i].gap != 0) chk($sformatf("gap_%0d", i), hs_cyc - hs_cyc_prev, vecs[i].gap);
    end
    chk("stable_a", stab_a, 0);
    chk("stable_b", stab_b, 0);

    // DONE: CPU owns the RAM bus, then reload hands it back to the loader
    @(posedge clk); #1;
    ifa.cpu_a = 16'h1000; ifa.cpu_oe = 1'b0;
    #1;
    chk("done_mem_a",   {16'd0, ifa.mem_a},   32'h00001000);
    chk("done_mem_oe0", {31'd0, ifa.mem_oe},  32'd0);
    chk("done_ld_d_en", {31'd0, ifa.ld_d_en}, 32'd0);
    ifa.cpu_oe = 1'b1;
    #1;
    chk("done_mem_oe1", {31'd0, ifa.mem_oe},  32'd1);
    ifa.cpu_we = 1'b0;
    #1;
    chk("done_mem_we0", {31'd0, ifa.mem_we},  32'd0);
    ifa.cpu_we = 1'b1; ifa.cpu_oe = 1'b0; ifa.reload = 1'b1;
    @(posedge clk); #1;
    ifa.reload = 1'b0;
    chk("reload_cpu_rst_n", {31'd0, ifa.cpu_rst_n},  32'd0);
    chk("reload_s_ready",   {31'd0, ifa.s_ready},    32'd1);
    chk("reload_count",     {15'd0, ifa.byte_count}, 32'd0);
    chk("reload_done",      {31'd0, ifa.done},       32'd0);
    chk("reload_mem_a",     {16'd0, ifa.mem_a},      32'd0);
    chk("reload_mem_oe",    {31'd0, ifa.mem_oe},     32'd1);
    ifa.cpu_oe = 1'b1;

    // reload held through WAIT, SETUP and STROBE must not disturb the load
    drive(0, 1'b1, 8'h77, 1'b1);
    ifa.reload = 1'b1;
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h77, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ifa.reload = 1'b0;
    @(posedge clk); #1;
    chk("ign_done",      {31'd0, ifa.done},       32'd1);
    chk("ign_cpu_rst_n", {31'd0, ifa.cpu_rst_n},  32'd1);
    chk("ign_count",     {15'd0, ifa.byte_count}, 32'd1);
    chk("ign_ram",       {24'd0, ram_a[16'h0000]}, 32'h77);
    repeat (2) @(posedge clk);
    #1;
    chk("ign_done_hold", {31'd0, ifa.done},       32'd1);

    // Reset in the middle of a strobe
    ifa.reload = 1'b1;
    @(posedge clk); #1;
    ifa.reload = 1'b0;
    drive(0, 1'b1, 8'h11, 1'b0);
    @(posedge clk); #1;
    drive(0, 1'b0, 8'h11, 1'b0);
    @(posedge clk); #2;
    chk("mid_strobe_we", {31'd0, ifa.mem_we}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_async_we",        {31'd0, ifa.mem_we},    32'd1);
    chk("rst_async_cpu_rst_n", {31'd0, ifa.cpu_rst_n}, 32'd0);
    chk("rst_async_ld_d_en",   {31'd0, ifa.ld_d_en},   32'd0);
    chk("rst_async_mem_a",     {16'd0, ifa.mem_a},     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'h5A, 1'b1, 0);
    chk("after_rst_ram",   {24'd0, ram_a[16'h0000]}, 32'h5A);
    chk("after_rst_count", {15'd0, ifa.byte_count},  32'd1);
    chk("after_rst_done",  {31'd0, ifa.done},        32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
